// File: rtl/mips_lsu_pkg.sv
// Shared encodings for the MIPS load/store unit: access sizes, error codes
// and the control FSM state type.
package mips_lsu_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    localparam logic [1:0] ERR_OK       = 2'd0;
    localparam logic [1:0] ERR_MISALIGN = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT  = 2'd2;
    localparam logic [1:0] ERR_SIZE     = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_e;

endpackage

// File: rtl/mips_lsu_if.sv
// Core-request / response / data-memory bundle of the load/store unit.
// master = environment side (core + memory), slave = the LSU itself.
interface mips_lsu_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32
) ();
    localparam int B = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [1:0]            req_size;
    logic                  req_unsigned;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;

    logic                  rsp_valid;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic [1:0]            rsp_err;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [B-1:0]          mem_be;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_ack;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        output mem_ack, mem_rdata
    );

    modport slave (
        input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_be, mem_wdata,
        input  mem_ack, mem_rdata
    );

endinterface

// File: rtl/mips_lsu_lane_align.sv
// Byte-lane arithmetic: byte enables, store-data shift into lane position,
// and load-data shift/mask/extension back to a right-justified value.
module lsu_lane_align
    import mips_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int B          = DATA_WIDTH / 8,
    parameter int OFF_W      = $clog2(B)
) (
    input  logic [OFF_W-1:0]      offset,
    input  logic [1:0]            size,
    input  logic                  is_unsigned,
    input  logic [DATA_WIDTH-1:0] wdata_in,
    input  logic [DATA_WIDTH-1:0] rdata_in,
    output logic [B-1:0]          be,
    output logic [DATA_WIDTH-1:0] wdata_out,
    output logic [DATA_WIDTH-1:0] rdata_out
);

    logic [7:0]            lane_mask_s;
    logic [B-1:0]          lane_mask_b_s;
    logic [DATA_WIDTH-1:0] shifted_s;
    logic [DATA_WIDTH-1:0] keep_s;
    logic                  sign_s;
    logic                  fill_s;

    // Per-size lane mask, data-keep mask and sign bit of the shifted load data.
    always_comb begin
        shifted_s = rdata_in >> {offset, 3'b000};
        case (size)
            SZ_BYTE: begin
                lane_mask_s = 8'h01;
                keep_s      = DATA_WIDTH'(8'hFF);
                sign_s      = shifted_s[7];
            end
            SZ_HALF: begin
                lane_mask_s = 8'h03;
                keep_s      = DATA_WIDTH'(16'hFFFF);
                sign_s      = shifted_s[15];
            end
            SZ_WORD: begin
                lane_mask_s = 8'h0F;
                keep_s      = DATA_WIDTH'(32'hFFFF_FFFF);
                sign_s      = shifted_s[31];
            end
            default: begin
                lane_mask_s = 8'hFF;
                keep_s      = {DATA_WIDTH{1'b1}};
                sign_s      = shifted_s[DATA_WIDTH-1];
            end
        endcase
        lane_mask_b_s = lane_mask_s[B-1:0];
        fill_s        = sign_s & ~is_unsigned;
        be            = lane_mask_b_s << offset;
        wdata_out     = wdata_in << {offset, 3'b000};
        if (fill_s) begin
            rdata_out = (shifted_s & keep_s) | ~keep_s;
        end else begin
            rdata_out = shifted_s & keep_s;
        end
    end

endmodule

// File: rtl/mips_lsu.sv
// Load/store unit between the MIPS core and data memory: one outstanding
// request, variable-latency memory handshake, timeout abort, and
// misalignment / size checking. All outputs are registered.
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic       clk,
    input  logic       rst,
    mips_lsu_if.slave  bus
);

    localparam int B     = DATA_WIDTH / 8;
    localparam int OFF_W = $clog2(B);
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    lsu_state_e            state_q, state_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_err_q, rsp_err_d;
    logic                  mem_req_q, mem_req_d;
    logic                  mem_we_q, mem_we_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [B-1:0]          mem_be_q, mem_be_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [1:0]            size_q, size_d;
    logic                  unsigned_q, unsigned_d;
    logic [OFF_W-1:0]      offset_q, offset_d;

    logic [OFF_W-1:0]      req_offset_s;
    logic [4:0]            req_bytes_s;
    logic [4:0]            req_bytes_m1_s;
    logic                  accept_s;
    logic                  bad_size_s;
    logic                  misalign_s;
    logic                  timeout_s;
    logic [CNT_W-1:0]      cnt_inc_s;

    logic [OFF_W-1:0]      sel_offset_s;
    logic [1:0]            sel_size_s;
    logic                  sel_unsigned_s;
    logic [B-1:0]          lane_be_s;
    logic [DATA_WIDTH-1:0] lane_wdata_s;
    logic [DATA_WIDTH-1:0] lane_rdata_s;

    assign req_offset_s   = bus.req_addr[OFF_W-1:0];
    assign req_bytes_s    = 5'd1 << bus.req_size;
    assign req_bytes_m1_s = req_bytes_s - 5'd1;
    assign accept_s       = (state_q == ST_IDLE) && bus.req_valid;
    assign bad_size_s     = req_bytes_s > 5'(B);
    assign misalign_s     = (req_offset_s & req_bytes_m1_s[OFF_W-1:0]) != {OFF_W{1'b0}};
    assign cnt_inc_s      = cnt_q + CNT_W'(1);
    assign timeout_s      = (cnt_inc_s == CNT_W'(TIMEOUT));

    // Lane unit sees the incoming request while idle, the latched one otherwise.
    always_comb begin
        if (state_q == ST_IDLE) begin
            sel_offset_s   = req_offset_s;
            sel_size_s     = bus.req_size;
            sel_unsigned_s = bus.req_unsigned;
        end else begin
            sel_offset_s   = offset_q;
            sel_size_s     = size_q;
            sel_unsigned_s = unsigned_q;
        end
    end

    lsu_lane_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_lane (
        .offset      (sel_offset_s),
        .size        (sel_size_s),
        .is_unsigned (sel_unsigned_s),
        .wdata_in    (bus.req_wdata),
        .rdata_in    (bus.mem_rdata),
        .be          (lane_be_s),
        .wdata_out   (lane_wdata_s),
        .rdata_out   (lane_rdata_s)
    );

    // State and registered-output flops; async reset drops mem_req at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= {DATA_WIDTH{1'b0}};
            rsp_err_q   <= ERR_OK;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= {ADDR_WIDTH{1'b0}};
            mem_be_q    <= {B{1'b0}};
            mem_wdata_q <= {DATA_WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            size_q      <= SZ_BYTE;
            unsigned_q  <= 1'b0;
            offset_q    <= {OFF_W{1'b0}};
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_be_q    <= mem_be_d;
            mem_wdata_q <= mem_wdata_d;
            cnt_q       <= cnt_d;
            size_q      <= size_d;
            unsigned_q  <= unsigned_d;
            offset_q    <= offset_d;
        end
    end

    // Next-state: checks at accept, then wait for ack (ack beats timeout).
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    if (bad_size_s || misalign_s) begin
                        state_d = ST_RESP;
                    end else begin
                        state_d = ST_ACCESS;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack || timeout_s) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_ACCESS;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output/datapath next values: memory command, counter and response.
    always_comb begin
        req_ready_d = req_ready_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_be_d    = mem_be_q;
        mem_wdata_d = mem_wdata_q;
        cnt_d       = cnt_q;
        size_d      = size_q;
        unsigned_d  = unsigned_q;
        offset_d    = offset_q;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    req_ready_d = 1'b0;
                    size_d      = bus.req_size;
                    unsigned_d  = bus.req_unsigned;
                    offset_d    = req_offset_s;
                    if (bad_size_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_SIZE;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else if (misalign_s) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = ERR_MISALIGN;
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        mem_req_d   = 1'b1;
                        mem_we_d    = bus.req_write;
                        mem_addr_d  = {bus.req_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
                        mem_be_d    = lane_be_s;
                        mem_wdata_d = lane_wdata_s;
                        cnt_d       = {CNT_W{1'b0}};
                    end
                end else begin
                    req_ready_d = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (bus.mem_ack) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_OK;
                    if (mem_we_q) begin
                        rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    end else begin
                        rsp_rdata_d = lane_rdata_s;
                    end
                end else if (timeout_s) begin
                    mem_req_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = ERR_TIMEOUT;
                    rsp_rdata_d = {DATA_WIDTH{1'b0}};
                    cnt_d       = cnt_inc_s;
                end else begin
                    cnt_d = cnt_inc_s;
                end
            end
            ST_RESP: begin
                req_ready_d = 1'b1;
            end
            default: begin
                req_ready_d = 1'b1;
                mem_req_d   = 1'b0;
            end
        endcase
    end

    assign bus.req_ready = req_ready_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_be    = mem_be_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_mips_lsu.sv
// Directed bench for mips_lsu (DATA_WIDTH=32, TIMEOUT=4).
module tb_mips_lsu;

    logic clk;
    logic rst;
    int   errors;
    int   checks;
    int   req_hi;
    int   rsp_cnt;
    logic [1:0] seen_err;

    mips_lsu_if #(.DATA_WIDTH(32), .ADDR_WIDTH(32)) bus ();

    mips_lsu #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (32),
        .TIMEOUT    (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_req(input logic wr, input logic [1:0] sz, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wd);
        bus.req_valid    = 1'b1;
        bus.req_write    = wr;
        bus.req_size     = sz;
        bus.req_unsigned = uns;
        bus.req_addr     = addr;
        bus.req_wdata    = wd;
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_size = 2'd0;
        bus.req_unsigned = 1'b0;
        bus.req_addr = 32'h0;
        bus.req_wdata = 32'h0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 32'h0;

        // Reset state
        tick();
        tick();
        check("rst_req_ready", 64'(bus.req_ready), 64'h1);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        check("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("rst_rsp_err", 64'(bus.rsp_err), 64'h0);
        check("rst_mem_req", 64'(bus.mem_req), 64'h0);
        check("rst_mem_we", 64'(bus.mem_we), 64'h0);
        check("rst_mem_be", 64'(bus.mem_be), 64'h0);
        check("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("rst_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        rst = 1'b0;
        tick();

        // lb 0x1003, word 0x80FF_1234, immediate ack
        drive_req(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("lb_mem_req", 64'(bus.mem_req), 64'h1);
        check("lb_mem_addr", 64'(bus.mem_addr), 64'h1000);
        check("lb_mem_be", 64'(bus.mem_be), 64'h8);
        check("lb_mem_we", 64'(bus.mem_we), 64'h0);
        check("lb_ready_low", 64'(bus.req_ready), 64'h0);
        check("lb_no_rsp_yet", 64'(bus.rsp_valid), 64'h0);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h80FF_1234;
        tick();
        bus.mem_ack = 1'b0;
        check("lb_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("lb_rsp_rdata", 64'(bus.rsp_rdata), 64'hFFFF_FF80);
        check("lb_rsp_err", 64'(bus.rsp_err), 64'h0);
        check("lb_mem_req_drop", 64'(bus.mem_req), 64'h0);
        check("lb_ready_resp", 64'(bus.req_ready), 64'h0);
        tick();
        check("lb_rsp_pulse", 64'(bus.rsp_valid), 64'h0);
        check("lb_ready_back", 64'(bus.req_ready), 64'h1);

        // lhu 0x2002, word 0xBEEF_0000, three wait cycles
        drive_req(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        bus.mem_rdata = 32'hBEEF_0000;
        check("lhu_mem_be", 64'(bus.mem_be), 64'hC);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("lhu_wait_req", 64'(bus.mem_req), 64'h1);
            check("lhu_wait_norsp", 64'(bus.rsp_valid), 64'h0);
        end
        bus.mem_ack = 1'b1;
        tick();
        bus.mem_ack = 1'b0;
        check("lhu_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("lhu_rsp_rdata", 64'(bus.rsp_rdata), 64'h0000_BEEF);
        check("lhu_rsp_err", 64'(bus.rsp_err), 64'h0);
        tick();

        // sh 0x3002, wdata 0x0000_ABCD
        drive_req(1'b1, 2'd1, 1'b0, 32'h3002, 32'h0000_ABCD);
        tick();
        bus.req_valid = 1'b0;
        check("sh_mem_we", 64'(bus.mem_we), 64'h1);
        check("sh_mem_be", 64'(bus.mem_be), 64'hC);
        check("sh_mem_wdata", 64'(bus.mem_wdata), 64'hABCD_0000);
        check("sh_mem_addr", 64'(bus.mem_addr), 64'h3000);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h1234_5678;
        tick();
        bus.mem_ack = 1'b0;
        check("sh_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("sh_rsp_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("sh_rsp_err", 64'(bus.rsp_err), 64'h0);
        tick();

        // lw 0x4001 misaligned
        drive_req(1'b0, 2'd2, 1'b0, 32'h4001, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("lw_mis_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("lw_mis_err", 64'(bus.rsp_err), 64'h1);
        check("lw_mis_rdata", 64'(bus.rsp_rdata), 64'h0);
        check("lw_mis_no_mem", 64'(bus.mem_req), 64'h0);
        check("lw_mis_ready", 64'(bus.req_ready), 64'h0);
        tick();
        check("lw_mis_pulse", 64'(bus.rsp_valid), 64'h0);
        check("lw_mis_no_mem2", 64'(bus.mem_req), 64'h0);
        check("lw_mis_ready2", 64'(bus.req_ready), 64'h1);

        // sd on a 32-bit bus: bad size
        drive_req(1'b1, 2'd3, 1'b0, 32'h5000, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("sd_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("sd_err", 64'(bus.rsp_err), 64'h3);
        check("sd_no_mem", 64'(bus.mem_req), 64'h0);
        tick();
        check("sd_no_mem2", 64'(bus.mem_req), 64'h0);

        // Timeout: lw 0x6000, no ack
        drive_req(1'b0, 2'd2, 1'b0, 32'h6000, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        req_hi = 0;
        rsp_cnt = 0;
        seen_err = 2'd0;
        for (int i = 0; i < 10; i++) begin
            if (bus.mem_req) req_hi++;
            if (bus.rsp_valid) begin
                rsp_cnt++;
                seen_err = bus.rsp_err;
            end
            tick();
        end
        check("to_req_cycles", 64'(req_hi), 64'd4);
        check("to_rsp_count", 64'(rsp_cnt), 64'd1);
        check("to_err", 64'(seen_err), 64'h2);
        check("to_ready", 64'(bus.req_ready), 64'h1);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'hFFFF_FFFF;
        tick();
        check("late_ack_norsp", 64'(bus.rsp_valid), 64'h0);
        check("late_ack_nomem", 64'(bus.mem_req), 64'h0);
        tick();
        check("late_ack_norsp2", 64'(bus.rsp_valid), 64'h0);
        bus.mem_ack = 1'b0;

        // Normal request after the timeout: lbu 0x7001
        drive_req(1'b0, 2'd0, 1'b1, 32'h7001, 32'h0);
        tick();
        bus.req_valid = 1'b0;
        check("lbu_mem_req", 64'(bus.mem_req), 64'h1);
        check("lbu_mem_be", 64'(bus.mem_be), 64'h2);
        bus.mem_ack = 1'b1;
        bus.mem_rdata = 32'h0000_9A00;
        tick();
        bus.mem_ack = 1'b0;
        check("lbu_rsp_valid", 64'(bus.rsp_valid), 64'h1);
        check("lbu_rsp_rdata", 64'(bus.rsp_rdata), 64'h0000_009A);
        check("lbu_rsp_err", 64'(bus.rsp_err), 64'h0);
        tick();

        // Reset asserted mid-ACCESS
        drive_req(1'b1, 2'd2, 1'b0, 32'h8000, 32'hDEAD_BEEF);
        tick();
        bus.req_valid = 1'b0;
        check("ra_mem_req", 64'(bus.mem_req), 64'h1);
        #2;
        rst = 1'b1;
        #1;
        check("ra_mem_req_drop", 64'(bus.mem_req), 64'h0);
        check("ra_mem_we", 64'(bus.mem_we), 64'h0);
        check("ra_mem_addr", 64'(bus.mem_addr), 64'h0);
        check("ra_mem_be", 64'(bus.mem_be), 64'h0);
        check("ra_mem_wdata", 64'(bus.mem_wdata), 64'h0);
        check("ra_ready", 64'(bus.req_ready), 64'h1);
        check("ra_rsp_valid", 64'(bus.rsp_valid), 64'h0);
        bus.mem_ack = 1'b1;
        tick();
        rst = 1'b0;
        bus.mem_ack = 1'b0;
        rsp_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (bus.rsp_valid) rsp_cnt++;
        end
        check("ra_no_rsp", 64'(rsp_cnt), 64'd0);
        check("ra_ready_after", 64'(bus.req_ready), 64'h1);
        check("ra_mem_idle", 64'(bus.mem_req), 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mips_lsu.md
# mips_lsu

Parametrised load/store unit that sits between the MIPS datapath's ALU address output and the data memory, replacing the fixed single-cycle DMEM access and its byte/half/word load mux. It accepts one memory request at a time from the core over a valid/ready handshake. It generates byte enables and aligned addresses, and waits a variable number of cycles for a memory acknowledge. It returns a sign- or zero-extended load result with an error code, and flags misaligned, oversize and timed-out accesses instead of silently corrupting data.

## Interface
- DATA_WIDTH, 32, memory word width in bits; 32 or 64; lanes B = DATA_WIDTH/8
- ADDR_WIDTH, 32, byte address width
- TIMEOUT, 255, max cycles waiting for mem_ack before abort; ≥1
- Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-high
- req_valid  in  1  core presents a request
- req_ready  out  1  LSU can accept; high only in IDLE
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  0 byte, 1 half, 2 word, 3 dword
- req_unsigned  in  1  load zero-extends (lbu/lhu) when 1, sign-extends when 0
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  DATA_WIDTH  store data, right-justified
- rsp_valid  out  1  one-cycle response pulse
- rsp_rdata  out  DATA_WIDTH  extended load data; 0 for stores and errors
- rsp_err  out  2  0 ok, 1 misaligned, 2 timeout, 3 bad size
- mem_req  out  1  memory access request, held until ack or abort
- mem_we  out  1  write strobe
- mem_addr  out  ADDR_WIDTH  address with low log2(B) bits forced to 0
- mem_be  out  B  byte enables
- mem_wdata  out  DATA_WIDTH  store data shifted into lane position
- mem_ack  in  1  memory completes access this cycle
- mem_rdata  in  DATA_WIDTH  read data, valid with mem_ack

## Operation
- FSM states: IDLE, ACCESS, RESP.
- IDLE: req_ready=1. On req_valid the request is latched. The offset is addr[log2(B)-1:0] and the size in bytes is 2^size.
  - If the size in bytes exceeds B: go to RESP with err=3.
  - Else, if the offset is not a multiple of the size: go to RESP with err=1. No memory cycle is issued for either error.
  - Else go to ACCESS.
- ACCESS: mem_req=1; mem_addr, mem_we, mem_be and mem_wdata stay stable.
  - mem_be = ((1<<bytes)-1) << offset.
  - mem_wdata = req_wdata << (8*offset).
  - On mem_ack: for a load, rdata = mem_rdata >> (8*offset), masked to the size, then sign- or zero-extended to DATA_WIDTH. Go to RESP with err=0.
  - The timeout counter resets on entry and increments each cycle without ack. When it reaches TIMEOUT with no ack: drop mem_req and go to RESP with err=2.
- RESP: rsp_valid=1 for exactly one cycle, then go to IDLE.
- mem_ack outside ACCESS is ignored.
- A dword access with DATA_WIDTH=32 is bad size (err=3).

## Timing
- Reset values: state IDLE, req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0, counter=0.
- All outputs are registered.
- Accept at edge N. mem_req is high from N+1.
- Ack sampled at edge N+1+k, with k wait cycles. rsp_valid is high in cycle N+2+k, so the best-case latency is 2 cycles.
- Error path: rsp_valid is high in cycle N+1.
- req_ready is low from N+1 through the RESP cycle. The next request is accepted at the earliest on the edge after RESP, for a throughput of one request per ≥3 cycles.
- Timeout: with TIMEOUT=T, mem_req is high for exactly T cycles before abort.
- Ack and timeout in the same cycle: ack wins, and the response is err=0.
- rst asserted mid-ACCESS: mem_req drops immediately (asynchronous) and the pending response is discarded.

## Structure
- Package mips_lsu_pkg holds:
  - size encodings (SZ_BYTE..SZ_DWORD);
  - error codes (ERR_OK, ERR_MISALIGN, ERR_TIMEOUT, ERR_SIZE);
  - the state enum.
- One combinational sub-module, lsu_lane_align: computes be, wdata shift, rdata shift/mask/extend from offset, size and unsigned. This keeps the FSM module free of lane arithmetic.
- Timeout counter width is $clog2(TIMEOUT+1).

## Test plan
- DATA_WIDTH=32, lb, addr 0x1003, memory word 0x80FF_1234, ack after 0 waits -> mem_addr 0x1000, mem_be 4'b1000, rsp_rdata 0xFFFF_FF80, err 0, rsp_valid 2 cycles after accept.
- lhu, addr 0x2002, word 0xBEEF_0000, ack after 3 waits -> rsp_rdata 0x0000_BEEF. rsp_valid arrives 5 cycles after accept.
- sh, addr 0x3002, wdata 0x0000_ABCD -> mem_we 1, mem_be 4'b1100, mem_wdata 0xABCD_0000, rsp_rdata 0, err 0.
- lw at 0x4001, and sd with DATA_WIDTH=32 -> err 1 and err 3 respectively. mem_req never asserts, and rsp_valid arrives 1 cycle after accept.
- TIMEOUT=4, mem_ack held low -> mem_req high for exactly 4 cycles, then err 2. A late mem_ack is ignored, and the next request is accepted normally.
- rst pulsed while in ACCESS -> all outputs return to reset values immediately. No rsp_valid is produced, and req_ready=1 after rst is released.
